// File: rtl/cmac_stat_pkg.sv
// Shared types and helpers for the CMAC statistics scheduler.
package cmac_stat_pkg;

  localparam int SEQ_W_DEF = 16;
  localparam int DROP_W    = 16;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_DRAIN = 1'b1;

  // Increment that sticks at max_val; callers zero-extend narrower counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/cmac_stat_accum.sv
// One channel: saturating window accumulator plus its snapshot register.
module cmac_stat_accum
  import cmac_stat_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_pulse,
  input  logic             i_boundary,
  input  logic             i_load,
  output logic [CNT_W-1:0] o_snap_next,
  output logic [CNT_W-1:0] o_snap
);

  localparam logic [31:0] ACC_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_snap;
  logic [CNT_W-1:0] w_sum;

  // A pulse on the boundary cycle still belongs to the closing window.
  assign w_sum = i_pulse ? CNT_W'(sat_inc(32'(r_acc), ACC_MAX)) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (!i_enable || i_boundary) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
    end else if (i_load) begin
      r_snap <= w_sum;
    end
  end

  assign o_snap_next = w_sum;
  assign o_snap      = r_snap;

endmodule

// File: rtl/cmac_stat_sched.sv
// Shared window timer, snapshot-and-drain FSM and registered stream output.
module cmac_stat_sched
  import cmac_stat_pkg::*;
#(
  parameter int NUM_CH             = 8,
  parameter int CNT_W              = 32,
  parameter int TIME_WINDOW_CYCLES = 322265625,
  parameter int SEQ_W              = SEQ_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         stat_pulse,
  input  logic                      enable,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(NUM_CH)-1:0] m_ch,
  output logic [CNT_W-1:0]          m_count,
  output logic [SEQ_W-1:0]          m_seq,
  output logic                      m_last,
  output logic                      overrun,
  output logic [DROP_W-1:0]         drop_cnt,
  output logic                      busy
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int TMR_W = (TIME_WINDOW_CYCLES > 1) ? $clog2(TIME_WINDOW_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIME_WINDOW_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [31:0]      DROP_MAX = 32'((1 << DROP_W) - 1);

  state_t                      r_state;
  logic [TMR_W-1:0]            r_timer;
  logic [SEQ_W-1:0]            r_win_seq;
  logic [SEQ_W-1:0]            r_snap_seq;
  logic [CH_W-1:0]             r_idx;
  logic [CNT_W-1:0]            r_count;
  logic                        r_valid;
  logic                        r_last;
  logic                        r_overrun;
  logic [DROP_W-1:0]           r_drop_cnt;

  logic [NUM_CH-1:0][CNT_W-1:0] w_snap_next;
  logic [NUM_CH-1:0][CNT_W-1:0] w_snap;
  logic [NUM_CH-1:0][CNT_W-1:0] w_view;
  logic [CH_W-1:0]              w_idx_nxt;
  logic [CH_W-1:0]              w_sel;
  logic                         w_boundary;
  logic                         w_accept;
  logic                         w_last_accept;
  logic                         w_load;
  logic                         w_drop;

  // Stream handshake: a beat transfers on any edge where m_valid && m_ready;
  // m_valid is registered, never waits on m_ready, and the beat fields hold
  // until that transfer happens.
  assign w_boundary    = enable && (r_timer == TMR_LAST);
  assign w_accept      = r_valid && m_ready;
  assign w_last_accept = w_accept && (r_idx == CH_LAST);
  assign w_load        = w_boundary && ((r_state == ST_IDLE) || w_last_accept);
  assign w_drop        = w_boundary && !w_load;
  assign w_idx_nxt     = r_idx + CH_W'(1);

  // On a load the first beat comes straight from the accumulators' next value.
  assign w_view = w_load ? w_snap_next : w_snap;
  assign w_sel  = w_load ? '0 : w_idx_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cmac_stat_accum #(.CNT_W(CNT_W)) u_accum (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_enable    (enable),
      .i_pulse     (stat_pulse[g]),
      .i_boundary  (w_boundary),
      .i_load      (w_load),
      .o_snap_next (w_snap_next[g]),
      .o_snap      (w_snap[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_win_seq <= '0;
    end else begin
      if (!enable || w_boundary) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (w_boundary) begin
        r_win_seq <= r_win_seq + SEQ_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_valid    <= 1'b0;
      r_idx      <= '0;
      r_count    <= '0;
      r_snap_seq <= '0;
      r_last     <= 1'b0;
    end else if (w_load) begin
      r_state    <= ST_DRAIN;
      r_valid    <= 1'b1;
      r_idx      <= '0;
      r_count    <= w_view[w_sel];
      r_snap_seq <= r_win_seq;
      r_last     <= 1'b0;
    end else if (w_last_accept) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= w_idx_nxt;
      r_count <= w_view[w_sel];
      r_last  <= (w_idx_nxt == CH_LAST);
    end
  end

  // A dropped window still advances the sequence and clears the accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overrun  <= 1'b1;
      r_drop_cnt <= DROP_W'(sat_inc(32'(r_drop_cnt), DROP_MAX));
    end
  end

  assign m_valid  = r_valid;
  assign m_ch     = r_idx;
  assign m_count  = r_count;
  assign m_seq    = r_snap_seq;
  assign m_last   = r_last;
  assign overrun  = r_overrun;
  assign drop_cnt = r_drop_cnt;
  assign busy     = (r_state == ST_DRAIN);

endmodule

// File: tb/tb_cmac_stat_sched.sv
// Bench for cmac_stat_sched: window table plus stall, overrun, enable, reset and saturation cases.
module tb_cmac_stat_sched;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int TW  = 16;
  localparam int SW  = 16;
  localparam int STW = 320;
  localparam int BW  = 2 + CW + SW + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           m_ready = 1'b1;
  logic [NCH-1:0] stat_pulse = '0;
  logic           m_valid, m_last, overrun, busy;
  logic [1:0]     m_ch;
  logic [CW-1:0]  m_count;
  logic [SW-1:0]  m_seq;
  logic [15:0]    drop_cnt;

  logic           s_en = 1'b0;
  logic           s_ready = 1'b1;
  logic [NCH-1:0] s_pulse = '0;
  logic           s_valid, s_last, s_ovr, s_busy;
  logic [1:0]     s_ch;
  logic [CW-1:0]  s_count;
  logic [SW-1:0]  s_seq;
  logic [15:0]    s_drop;

  cmac_stat_sched #(.NUM_CH(NCH), .CNT_W(CW), .TIME_WINDOW_CYCLES(TW), .SEQ_W(SW)) u_dut (
    .clk(clk), .rst_n(rst_n), .stat_pulse(stat_pulse), .enable(enable),
    .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_count(m_count),
    .m_seq(m_seq), .m_last(m_last), .overrun(overrun), .drop_cnt(drop_cnt), .busy(busy)
  );

  cmac_stat_sched #(.NUM_CH(NCH), .CNT_W(CW), .TIME_WINDOW_CYCLES(STW), .SEQ_W(SW)) u_sat (
    .clk(clk), .rst_n(rst_n), .stat_pulse(s_pulse), .enable(s_en),
    .m_valid(s_valid), .m_ready(s_ready), .m_ch(s_ch), .m_count(s_count),
    .m_seq(s_seq), .m_last(s_last), .overrun(s_ovr), .drop_cnt(s_drop), .busy(s_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             n [NCH];
    logic [NCH-1:0] b;
    int             e [NCH];
  } vec_t;

  vec_t           vecs [6];
  logic [BW-1:0]  exp_q [$];
  int             n_pass = 0;
  int             n_total = 0;
  logic [SW-1:0]  win_seq = '0;
  int             win_n [NCH];
  logic [NCH-1:0] win_b;
  logic [CW-1:0]  win_e [NCH];
  logic           v_at_boundary;
  logic           prev_stall = 1'b0;
  logic [BW-1:0]  prev_beat = '0;
  logic [BW-1:0]  cur_beat;
  logic [BW-1:0]  exp_beat;

  assign cur_beat = {m_ch, m_count, m_seq, m_last};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [CW-1:0] sat8(input int v);
    return (v > 255) ? 8'hFF : CW'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int a, input int b, input int c, input int d, input logic [NCH-1:0] bm);
    win_n = '{a, b, c, d};
    win_b = bm;
    for (int i = 0; i < NCH; i++) win_e[i] = sat8(win_n[i] + int'(win_b[i]));
  endtask

  task automatic check_reset_outputs();
    check("rst_m_valid",  32'(m_valid),  32'd0);
    check("rst_m_ch",     32'(m_ch),     32'd0);
    check("rst_m_count",  32'(m_count),  32'd0);
    check("rst_m_seq",    32'(m_seq),    32'd0);
    check("rst_m_last",   32'(m_last),   32'd0);
    check("rst_overrun",  32'(overrun),  32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
  endtask

  // Drives one full window starting at timer==0; channel i pulses on cycles
  // 0..n-1, plus the boundary cycle when its mask bit is set. m_ready is low
  // for window cycles [rlo, rhi).
  task automatic run_window(input int rlo, input int rhi, input bit push);
    if (push) begin
      for (int i = 0; i < NCH; i++)
        exp_q.push_back({2'(i), win_e[i], win_seq, (i == NCH - 1)});
    end
    for (int c = 0; c < TW; c++) begin
      for (int i = 0; i < NCH; i++)
        stat_pulse[i] = (c < win_n[i]) || ((c == TW - 1) && win_b[i]);
      m_ready = !((c >= rlo) && (c < rhi));
      if (c == TW - 1) v_at_boundary = m_valid;
      tick();
    end
    stat_pulse = '0;
    m_ready    = 1'b1;
    win_seq    = win_seq + 16'd1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        check("hold", 32'({m_valid, cur_beat}), 32'({1'b1, prev_beat}));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL beat_unexpected: got %h, no beat expected", cur_beat);
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat", 32'(cur_beat), 32'(exp_beat));
        end
      end
      prev_stall <= m_valid && !m_ready;
      prev_beat  <= cur_beat;
    end
  end

  initial begin
    int cnt [NCH];

    vecs[0].n = '{3, 5, 0, 16};  vecs[0].b = 4'b0000; vecs[0].e = '{3, 5, 0, 16};
    vecs[1].n = '{0, 0, 0, 0};   vecs[1].b = 4'b0000; vecs[1].e = '{0, 0, 0, 0};
    vecs[2].n = '{16, 1, 15, 7}; vecs[2].b = 4'b0000; vecs[2].e = '{16, 1, 15, 7};
    vecs[3].n = '{0, 0, 0, 0};   vecs[3].b = 4'b0010; vecs[3].e = '{0, 1, 0, 0};
    vecs[4].n = '{0, 0, 0, 0};   vecs[4].b = 4'b0000; vecs[4].e = '{0, 0, 0, 0};
    vecs[5].n = '{8, 8, 8, 9};   vecs[5].b = 4'b1000; vecs[5].e = '{8, 8, 8, 10};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n   = 1'b1;
    enable  = 1'b1;
    win_seq = '0;

    for (int k = 0; k < 6; k++) begin
      win_n = vecs[k].n;
      win_b = vecs[k].b;
      for (int i = 0; i < NCH; i++) win_e[i] = CW'(vecs[k].e[i]);
      run_window(0, 0, 1'b1);
      check("idle_at_boundary", 32'(v_at_boundary), 32'd0);
      check("first_beat_latency", 32'({m_valid, m_ch}), 32'({1'b1, 2'd0}));
    end

    // Stall the ch1 beat for five cycles.
    set_win(1, 2, 3, 4, 4'b0000);
    run_window(0, 0, 1'b1);
    set_win(0, 0, 0, 0, 4'b0000);
    run_window(1, 6, 1'b1);

    // Last beat accepted on the boundary cycle reloads without an overrun.
    set_win(5, 6, 7, 8, 4'b0000);
    run_window(0, 12, 1'b1);
    check("reload_valid", 32'({m_valid, m_ch}), 32'({1'b1, 2'd0}));
    check("reload_no_overrun", 32'({overrun, drop_cnt}), 32'd0);

    // Drain stalled across a whole window: that window is dropped.
    set_win(3, 3, 3, 3, 4'b0000);
    run_window(0, TW, 1'b0);
    check("overrun_set", 32'(overrun), 32'd1);
    set_win(2, 2, 2, 2, 4'b0000);
    run_window(0, 2, 1'b1);
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("drop_cnt_one", 32'(drop_cnt), 32'd1);

    // Disable mid-window; pulses while disabled must not count.
    for (int c = 0; c < 8; c++) begin
      stat_pulse = 4'b0001;
      tick();
    end
    enable     = 1'b0;
    stat_pulse = 4'b1111;
    repeat (20) tick();
    check("disabled_idle", 32'({m_valid, busy}), 32'd0);
    stat_pulse = '0;
    enable     = 1'b1;
    set_win(2, 0, 1, 3, 4'b0000);
    run_window(0, 0, 1'b1);
    check("reenable_full_window", 32'({m_valid, m_ch}), 32'({1'b1, 2'd0}));

    // Reset while a fresh drain is starting.
    set_win(1, 1, 1, 1, 4'b0000);
    run_window(0, 0, 1'b0);
    check("pre_reset_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs();
    rst_n   = 1'b1;
    win_seq = '0;
    set_win(4, 3, 2, 1, 4'b0000);
    run_window(0, 0, 1'b1);
    check("post_reset_no_early_beat", 32'(v_at_boundary), 32'd0);
    check("post_reset_first_beat", 32'({m_valid, m_ch, m_seq}), 32'({1'b1, 2'd0, 16'd0}));

    enable = 1'b0;
    repeat (6) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Saturation on the long-window instance.
    cnt  = '{0, 0, 0, 0};
    s_en = 1'b1;
    for (int c = 0; c < STW; c++) begin
      s_pulse[0] = (c >= 20);
      s_pulse[1] = (c < 255);
      s_pulse[2] = (c < 256);
      s_pulse[3] = (c == STW - 1);
      for (int i = 0; i < NCH; i++) cnt[i] += int'(s_pulse[i]);
      tick();
    end
    s_pulse = '0;
    s_en    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      check("sat_beat", 32'({s_valid, s_ch, s_count, s_seq, s_last}),
            32'({1'b1, 2'(i), sat8(cnt[i]), 16'd0, (i == NCH - 1)}));
      tick();
    end
    check("sat_done", 32'(s_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
